// File: rtl/program_loader.sv
// program_loader: fills instruction and data memory from a 32-bit
// valid/ready word stream, then raises the CPU start.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   load_en_i             pulse that opens a load session (IDLE/DONE)
//   data_i, valid_i       stream word (header or payload) and its valid
//   ready_o               loader accepts a word this cycle
//   imem_we/addr/data_o   registered instruction memory write port
//   dmem_we/addr/data_o   registered data memory write port
//   start_o, done_o       load complete, CPU may run
//   err_o                 sticky segment overflow flag
//
// Header word: [31] 0=imem 1=dmem, [30] last segment,
// [23:16] base word index, [15:0] payload word count.
module program_loader #(
    parameter int IMEM_DEPTH = 256,
    parameter int IMEM_AW    = 8,
    parameter int DMEM_DEPTH = 32,
    parameter int DMEM_AW    = 5
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_en_i,
    input  logic [31:0]        data_i,
    input  logic               valid_i,
    output logic               ready_o,
    output logic               imem_we_o,
    output logic [IMEM_AW-1:0] imem_addr_o,
    output logic [31:0]        imem_data_o,
    output logic               dmem_we_o,
    output logic [DMEM_AW-1:0] dmem_addr_o,
    output logic [31:0]        dmem_data_o,
    output logic               start_o,
    output logic               done_o,
    output logic               err_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HDR   = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    logic [2:0]  state;
    logic        seg_dmem;
    logic        seg_last;
    logic [7:0]  seg_base;
    logic [15:0] seg_cnt;
    logic [15:0] idx;
    logic        fin;

    logic        accept;
    logic [16:0] hdr_end;
    logic [16:0] hdr_depth;
    logic        hdr_ovf;
    logic        last_word;

    assign ready_o = (state == S_HDR) || (state == S_DATA);
    assign accept  = valid_i & ready_o;

    // Overflow is judged on the full 17-bit sum so base+count never wraps.
    assign hdr_end   = {9'd0, data_i[23:16]} + {1'b0, data_i[15:0]};
    assign hdr_depth = data_i[31] ? 17'(DMEM_DEPTH) : 17'(IMEM_DEPTH);
    assign hdr_ovf   = hdr_end > hdr_depth;

    assign last_word = (idx == seg_cnt - 16'd1);

    // fin is set one cycle into DONE, so the final write (issued during
    // DRAIN) has been in memory a full cycle before the CPU starts.
    assign start_o = fin;
    assign done_o  = fin;
    assign err_o   = (state == S_ERR);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            seg_dmem    <= 1'b0;
            seg_last    <= 1'b0;
            seg_base    <= '0;
            seg_cnt     <= '0;
            idx         <= '0;
            fin         <= 1'b0;
            imem_we_o   <= 1'b0;
            imem_addr_o <= '0;
            imem_data_o <= '0;
            dmem_we_o   <= 1'b0;
            dmem_addr_o <= '0;
            dmem_data_o <= '0;
        end else begin
            imem_we_o <= 1'b0;
            dmem_we_o <= 1'b0;
            unique case (1'b1)
                (state == S_IDLE): begin
                    if (load_en_i) begin
                        state <= S_HDR;
                    end
                end
                (state == S_HDR): begin
                    if (accept) begin
                        seg_dmem <= data_i[31];
                        seg_last <= data_i[30];
                        seg_base <= data_i[23:16];
                        seg_cnt  <= data_i[15:0];
                        idx      <= '0;
                        if (hdr_ovf) begin
                            state <= S_ERR;
                        end else if (data_i[15:0] == 16'd0) begin
                            state <= data_i[30] ? S_DRAIN : S_HDR;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                (state == S_DATA): begin
                    if (accept) begin
                        if (seg_dmem) begin
                            dmem_we_o   <= 1'b1;
                            dmem_addr_o <= DMEM_AW'(seg_base)
                                         + DMEM_AW'(idx);
                            dmem_data_o <= data_i;
                        end else begin
                            imem_we_o   <= 1'b1;
                            imem_addr_o <= IMEM_AW'(seg_base)
                                         + IMEM_AW'(idx);
                            imem_data_o <= data_i;
                        end
                        idx <= idx + 16'd1;
                        if (last_word) begin
                            state <= seg_last ? S_DRAIN : S_HDR;
                        end
                    end
                end
                (state == S_DRAIN): begin
                    state <= S_DONE;
                end
                (state == S_DONE): begin
                    if (load_en_i) begin
                        state <= S_HDR;
                        fin   <= 1'b0;
                    end else begin
                        fin <= 1'b1;
                    end
                end
                (state == S_ERR): begin
                    state <= S_ERR;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
